// File: rtl/window_buffer.sv
// window_buffer: shifts camera pixels into a BUFFER_H x BUFFER_W window and hands snapshots downstream over valid/ready
//   clock, reset     : system clock, synchronous active-high reset
//   pixel_in         : camera pixel, taken into the load row (bottom row) when shift_left is high
//   shift_left       : shift the load row left by one, pixel_in enters at the rightmost column
//   shift_up         : move every row up one position, top row discarded
//   buffer_rdy       : strobe to capture the current window into window_out
//   window_out       : snapshot, element (r,c) at bits [(r*BUFFER_W+c)*PIXEL_W +: PIXEL_W]
//   window_valid     : snapshot held and not yet consumed
//   window_ready     : consumer takes the snapshot when valid & ready
//   overflow         : sticky, a capture was dropped because the previous snapshot was still pending
//   frame_count      : captured snapshots, mod 256
module window_buffer #(
  parameter int BUFFER_W = 28,
  parameter int BUFFER_H = 28,
  parameter int PIXEL_W  = 8
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [PIXEL_W-1:0]                     pixel_in,
  input  logic                                   shift_left,
  input  logic                                   shift_up,
  input  logic                                   buffer_rdy,
  output logic [BUFFER_W*BUFFER_H*PIXEL_W-1:0]   window_out,
  output logic                                   window_valid,
  input  logic                                   window_ready,
  output logic                                   overflow,
  output logic [7:0]                             frame_count
);
  logic [BUFFER_H-1:0][BUFFER_W-1:0][PIXEL_W-1:0] store_q, store_d, win_q, win_d;
  logic       valid_q, valid_d, ovf_q, ovf_d, cap, drop;
  logic [7:0] cnt_q, cnt_d;
  assign cap  = buffer_rdy & (~valid_q | window_ready);
  assign drop = buffer_rdy & valid_q & ~window_ready;
  // Both shifts read store_q, so a combined shift moves the pre-shift load row up intact.
  always_comb begin
    store_d = store_q;
    if (shift_up)
      for (int r = 0; r < BUFFER_H-1; r++) store_d[r] = store_q[r+1];
    if (shift_left) begin
      for (int c = 0; c < BUFFER_W-1; c++) store_d[BUFFER_H-1][c] = store_q[BUFFER_H-1][c+1];
      store_d[BUFFER_H-1][BUFFER_W-1] = pixel_in;
    end
  end
  // The snapshot takes pre-edge storage, so a shift in the capture cycle is excluded.
  always_comb begin
    win_d   = cap ? store_q : win_q;
    valid_d = cap ? 1'b1 : (window_ready ? 1'b0 : valid_q);
    ovf_d   = ovf_q | drop;
    cnt_d   = cap ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      store_q <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      store_q <= store_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end
  assign window_out   = win_q;
  assign window_valid = valid_q;
  assign overflow     = ovf_q;
  assign frame_count  = cnt_q;
endmodule

// File: tb/tb_window_buffer.sv
// tb_window_buffer: directed and random stimulus for window_buffer (3x3, 8-bit) against an array-based reference model
module tb_window_buffer;
  localparam int W = 3, H = 3, P = 8, N = W*H*P;
  logic clock = 0, reset = 0, shift_left = 0, shift_up = 0, buffer_rdy = 0, window_ready = 0;
  logic [P-1:0] pixel_in = '0;
  logic [N-1:0] window_out;
  logic window_valid, overflow;
  logic [7:0] frame_count;
  int checks = 0, errors = 0;
  logic [7:0] m[H][W], snap[H][W];
  logic mv = 0, mo = 0;
  int mc = 0;
  logic [N-1:0] saved;

  window_buffer #(.BUFFER_W(W), .BUFFER_H(H), .PIXEL_W(P)) dut (
    .clock(clock), .reset(reset), .pixel_in(pixel_in), .shift_left(shift_left),
    .shift_up(shift_up), .buffer_rdy(buffer_rdy), .window_out(window_out),
    .window_valid(window_valid), .window_ready(window_ready), .overflow(overflow),
    .frame_count(frame_count));

  always #5 clock = ~clock;

  function automatic logic [N-1:0] snap_bits();
    logic [N-1:0] v = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) v[(r*W+c)*P +: P] = snap[r][c];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".out"}, window_out, snap_bits());
    chk({tag, ".valid"}, N'(window_valid), N'(mv));
    chk({tag, ".ovf"}, N'(overflow), N'(mo));
    chk({tag, ".cnt"}, N'(frame_count), N'(mc[7:0]));
  endtask

  task automatic do_reset();
    reset = 1; shift_left = 0; shift_up = 0; buffer_rdy = 0;
    @(posedge clock);
    foreach (m[r, c]) begin m[r][c] = 0; snap[r][c] = 0; end
    mv = 0; mo = 0; mc = 0;
    #1 reset = 0;
    chk_all("reset");
  endtask

  // One clock with the given strobes; the model applies the spec's rules to pre-edge state.
  task automatic step(input logic sl, input logic su, input logic br, input logic wr, input logic [7:0] px);
    logic [7:0] nm[H][W];
    shift_left = sl; shift_up = su; buffer_rdy = br; window_ready = wr; pixel_in = px;
    @(posedge clock);
    nm = m;
    if (su) for (int r = 0; r < H-1; r++) nm[r] = m[r+1];
    if (sl) begin
      for (int c = 0; c < W-1; c++) nm[H-1][c] = m[H-1][c+1];
      nm[H-1][W-1] = px;
    end
    if (br && (!mv || wr)) begin
      snap = m; mv = 1; mc = (mc + 1) % 256;
    end else if (br) mo = 1;
    else if (wr) mv = 0;
    m = nm;
    #1;
    shift_left = 0; shift_up = 0; buffer_rdy = 0;
    chk_all("step");
  endtask

  task automatic fill(input int base, input logic wr);
    for (int k = 1; k <= 9; k++) begin
      step(1, 0, 0, wr, 8'(base + k));
      if (k % 3 == 0 && k < 9) step(0, 1, 0, wr, 8'hAA);
    end
  endtask

  initial begin
    @(negedge clock);
    do_reset();
    chk("reset_out", window_out, '0);
    // fill and capture with ready
    fill(0, 1);
    step(0, 0, 1, 1, 0);
    chk("fill_out", window_out, 72'h090807060504030201);
    chk("fill_valid", N'(window_valid), N'(1));
    chk("fill_cnt", N'(frame_count), N'(1));
    step(0, 0, 0, 1, 0);
    chk("fill_consumed", N'(window_valid), N'(0));
    // backpressure and drop
    do_reset();
    fill(0, 0);
    step(0, 0, 1, 0, 0);
    saved = window_out;
    for (int i = 0; i < 10; i++) step(i % 2 == 0, i % 3 == 0, 0, 0, 8'(40 + i));
    chk("bp_stable", window_out, saved);
    step(0, 0, 1, 0, 0);
    chk("bp_ovf", N'(overflow), N'(1));
    chk("bp_cnt", N'(frame_count), N'(1));
    chk("bp_out", window_out, 72'h090807060504030201);
    step(0, 0, 0, 1, 0);
    chk("bp_drop_valid", N'(window_valid), N'(0));
    chk("bp_ovf_sticky", N'(overflow), N'(1));
    // same-cycle consume and capture
    do_reset();
    fill(0, 0);
    step(0, 0, 1, 0, 0);
    fill(10, 0);
    step(0, 0, 1, 1, 0);
    chk("cc_out", window_out, 72'h131211100f0e0d0c0b);
    chk("cc_valid", N'(window_valid), N'(1));
    chk("cc_ovf", N'(overflow), N'(0));
    chk("cc_cnt", N'(frame_count), N'(2));
    // simultaneous shifts, then capture alongside a left shift
    do_reset();
    for (int k = 1; k <= 3; k++) step(1, 0, 0, 1, 8'(k));
    step(1, 1, 0, 1, 8'd4);
    step(1, 0, 1, 1, 8'd5);
    chk("sim_out", window_out, 72'h040302030201000000);
    // reset mid-fill
    for (int k = 1; k <= 5; k++) step(1, 0, 0, 1, 8'(60 + k));
    do_reset();
    step(0, 0, 1, 1, 0);
    chk("rmf_out", window_out, '0);
    chk("rmf_cnt", N'(frame_count), N'(1));
    // wrap
    do_reset();
    for (int i = 0; i < 256; i++) step(0, 0, 1, 1, 0);
    chk("wrap_cnt", N'(frame_count), N'(0));
    chk("wrap_ovf", N'(overflow), N'(0));
    // random
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      else step(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 8'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
